vram_port_arb: RTL

VRAM_PORT_ARB -- requirements
Module: vram_port_arb

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_grant_pick.sv | 47 ++++
 rtl/vram_port_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM port arbiter.
// MCB command encodings, FSM states and bus widths.
package vram_pkg;

    localparam int AW  = 30;
    localparam int BLW = 6;
    localparam int DW  = 32;

    localparam logic [2:0] MCB_WR = 3'b000;
    localparam logic [2:0] MCB_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_FILL,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_DRAIN
    } state_t;

endpackage

// File: rtl/vram_grant_pick.sv
// Picks the write or read client in IDLE and remembers who won last.
// FAIR=1 alternates on ties, FAIR=0 always favours the reader.
module vram_grant_pick
    import vram_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic w_req,
    input  logic r_req,
    output logic grant_w,
    output logic grant_r
);

    logic last_w;

    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        if (arb_en) begin
            if (w_req && r_req) begin
                if (FAIR != 0 && !last_w) begin
                    grant_w = 1'b1;
                end else begin
                    grant_r = 1'b1;
                end
            end else begin
                grant_w = w_req;
                grant_r = r_req;
            end
        end
    end

    // Reset value "write" makes the reader win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_w <= 1'b1;
        end else if (grant_w) begin
            last_w <= 1'b1;
        end else if (grant_r) begin
            last_w <= 1'b0;
        end
    end

endmodule

// File: rtl/vram_port_arb.sv
// Two-client (write/read) burst arbiter in front of one MCB user port.
// Strobes are combinational so FIFO backpressure costs no extra cycles.
module vram_port_arb
    import vram_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           calib_done,
    input  logic           w_req,
    input  logic [AW-1:0]  w_addr,
    input  logic [BLW-1:0] w_bl,
    input  logic [DW-1:0]  w_data,
    output logic           w_data_rd,
    output logic           w_done,
    input  logic           r_req,
    input  logic [AW-1:0]  r_addr,
    input  logic [BLW-1:0] r_bl,
    output logic [DW-1:0]  r_data,
    output logic           r_valid,
    output logic           r_done,
    output logic           mcb_cmd_en,
    output logic [2:0]     mcb_cmd_instr,
    output logic [BLW-1:0] mcb_cmd_bl,
    output logic [AW-1:0]  mcb_cmd_byte_addr,
    input  logic           mcb_cmd_full,
    output logic           mcb_wr_en,
    output logic [DW-1:0]  mcb_wr_data,
    output logic [3:0]     mcb_wr_mask,
    input  logic           mcb_wr_full,
    output logic           mcb_rd_en,
    input  logic [DW-1:0]  mcb_rd_data,
    input  logic           mcb_rd_empty
);

    state_t         state;
    logic [AW-1:0]  addr_q;
    logic [BLW-1:0] bl_q;
    logic [BLW-1:0] cnt;
    logic [2:0]     instr_q;

    logic arb_en;
    logic grant_w;
    logic grant_r;
    logic wr_beat;
    logic rd_beat;
    logic cmd_go;
    logic last;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{w_addr[1:0], r_addr[1:0]};

    assign arb_en = (state == ST_IDLE) && calib_done;

    vram_grant_pick #(
        .FAIR(FAIR)
    ) u_pick (
        .clk    (clk),
        .reset  (reset),
        .arb_en (arb_en),
        .w_req  (w_req),
        .r_req  (r_req),
        .grant_w(grant_w),
        .grant_r(grant_r)
    );

    // Strobes are masked during reset so an abandoned burst moves no data.
    assign wr_beat = !reset && (state == ST_WR_FILL) && !mcb_wr_full;
    assign rd_beat = !reset && (state == ST_RD_DRAIN) && !mcb_rd_empty;
    assign cmd_go  = !reset && !mcb_cmd_full &&
                     ((state == ST_WR_CMD) || (state == ST_RD_CMD));
    assign last    = (cnt == '0);

    assign mcb_wr_en   = wr_beat;
    assign w_data_rd   = wr_beat;
    assign mcb_wr_data = w_data;
    assign mcb_wr_mask = 4'b0000;

    assign mcb_rd_en = rd_beat;
    assign r_valid   = rd_beat;
    assign r_data    = mcb_rd_data;
    assign r_done    = rd_beat && last;

    assign mcb_cmd_en        = cmd_go;
    assign mcb_cmd_instr     = instr_q;
    assign mcb_cmd_bl        = bl_q;
    assign mcb_cmd_byte_addr = addr_q;
    assign w_done            = cmd_go && (state == ST_WR_CMD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            bl_q    <= '0;
            cnt     <= '0;
            instr_q <= MCB_WR;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_w) begin
                        addr_q  <= {w_addr[AW-1:2], 2'b00};
                        bl_q    <= w_bl;
                        cnt     <= w_bl;
                        instr_q <= MCB_WR;
                        state   <= ST_WR_FILL;
                    end else if (grant_r) begin
                        addr_q  <= {r_addr[AW-1:2], 2'b00};
                        bl_q    <= r_bl;
                        cnt     <= r_bl;
                        instr_q <= MCB_RD;
                        state   <= ST_RD_CMD;
                    end
                end
                ST_WR_FILL: begin
                    if (wr_beat) begin
                        if (last) begin
                            state <= ST_WR_CMD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_go) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_go) begin
                        state <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (rd_beat) begin
                        if (last) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
